sum3_operand_collector: RTL and testbench

- Upstream feeder for the 3-operand modulo-2^W adder. That adder is combinational and computes `out1 = in1 + in2 + in3 mod 2^W`.
- Accepts a serial stream of W-bit words over a valid/ready handshake and groups them into triplets. A short triplet can be closed early with a flush.
- Presents each triplet as registered, stable operands `op1`/`op2`/`op3` under a valid/ready handshake. These drive the adder's `in1`/`in2`/`in3`.
- Double-buffered: one collection bank, one output bank. The next triplet is collected while the current one is held.

---
 rtl/sum3_operand_collector_pkg.sv | 23 ++
 rtl/sum3_operand_collector.sv | 112 +++++++++++
 tb/tb_sum3_operand_collector.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum3_operand_collector_pkg.sv
// sum3_operand_collector_pkg
//   Shared types and constants for the 3-operand adder feeder.
//   - SUM3_W / SUM3_CNT_W : default operand and triplet-counter widths
//   - idx_t               : collection slot index; legal values are 0..2
//   - triplet_t           : three operands plus a "closed early" flag, the
//                           storage format of both the collection and output banks
package sum3_operand_collector_pkg;

  localparam int SUM3_W     = 4;
  localparam int SUM3_CNT_W = 8;

  localparam int SUM3_SLOTS = 3;

  typedef logic [1:0] idx_t;

  localparam idx_t IDX_LAST = 2'd2;

  typedef struct packed {
    logic [SUM3_SLOTS-1:0][SUM3_W-1:0] slot;     // slot[0] = first word
    logic                              partial;  // closed by flush before slot 2
  } triplet_t;

endpackage

// File: rtl/sum3_operand_collector.sv
// sum3_operand_collector
//   Groups a serial word stream into triplets and presents each triplet as
//   stable, registered operands for a combinational 3-operand adder.
//   Double-buffered: one bank collects while the other is held at the output.
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   s_valid/ready : input word handshake; s_data is the word
//   s_flush       : with s_valid, closes the triplet early (empty slots -> 0)
//   op1..op3      : held operands, to adder in1..in3
//   out_valid     : op1..op3 hold a valid triplet; out_ready consumes it
//   out_partial   : current triplet was closed by a flush before its 3rd word
//   trip_cnt      : wrapping count of triplets loaded into the output bank
module sum3_operand_collector
  import sum3_operand_collector_pkg::*;
#(
  parameter int W     = SUM3_W,
  parameter int CNT_W = SUM3_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_flush,
  output logic [W-1:0]     op1,
  output logic [W-1:0]     op2,
  output logic [W-1:0]     op3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_partial,
  output logic [CNT_W-1:0] trip_cnt
);

  idx_t     idx;
  logic     col_full;
  triplet_t col_bank;
  triplet_t col_next;
  triplet_t out_bank;

  logic accept;
  logic close;
  logic transfer;

  // s_ready depends only on registers (and rst), never on s_valid/out_ready.
  assign s_ready  = !rst && !col_full;
  assign accept   = s_valid && s_ready;
  assign close    = accept && ((idx == IDX_LAST) || s_flush);
  // accept needs !col_full and transfer needs col_full, so they never coincide.
  assign transfer = col_full && (!out_valid || out_ready);

  always_comb begin
    col_next = col_bank;
    if (accept) begin
      col_next.slot[idx] = s_data;
      if (close) begin
        // Zero the slots the early close left unfilled.
        for (int j = 0; j < SUM3_SLOTS; j++) begin
          if (j > int'(idx)) col_next.slot[j] = '0;
        end
        col_next.partial = (idx != IDX_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      col_full  <= 1'b0;
      col_bank  <= '0;
      out_bank  <= '0;
      out_valid <= 1'b0;
      trip_cnt  <= '0;
    end else begin
      col_bank <= col_next;

      if (accept) begin
        if (close) begin
          idx      <= '0;
          col_full <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
        end
      end else if (transfer) begin
        col_full <= 1'b0;
      end

      // A transfer in the same cycle as an output handshake replaces the
      // triplet directly, so out_valid stays high with no bubble.
      if (transfer) begin
        out_bank  <= col_bank;
        out_valid <= 1'b1;
        trip_cnt  <= trip_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign op1         = out_bank.slot[0];
  assign op2         = out_bank.slot[1];
  assign op3         = out_bank.slot[2];
  assign out_partial = out_bank.partial;

  always @(posedge clk) begin
    if (!rst) begin
      assert (idx != 2'd3)
        else $error("sum3_operand_collector: illegal collection index 3");
    end
  end

endmodule

// File: tb/tb_sum3_operand_collector.sv
module tb_sum3_operand_collector;
  import sum3_operand_collector_pkg::*;

  localparam int W     = SUM3_W;
  localparam int CNT_W = SUM3_CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             s_flush;
  logic [W-1:0]     op1, op2, op3;
  logic             out_valid;
  logic             out_ready;
  logic             out_partial;
  logic [CNT_W-1:0] trip_cnt;
  logic [W-1:0]     adder_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum3_operand_collector #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_flush     (s_flush),
    .op1         (op1),
    .op2         (op2),
    .op3         (op3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_partial (out_partial),
    .trip_cnt    (trip_cnt)
  );

  // Downstream 3-operand modulo-2^W adder.
  assign adder_out = op1 + op2 + op3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word and hold it until accepted (bounded).
  task automatic send_word(input logic [W-1:0] d, input logic fl);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_flush = fl;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%0b required 1 for word %h", s_ready, d);
    end
    step();
    s_valid = 1'b0;
    s_flush = 1'b0;
  endtask

  task automatic check_ops(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2,
                           input logic [W-1:0] e3, input logic ep);
    checks++;
    if ({op1, op2, op3, out_partial} !== {e1, e2, e3, ep}) begin
      errors++;
      $display("FAIL %s: ops=(%h,%h,%h) partial=%0b required (%h,%h,%h) partial=%0b",
               name, op1, op2, op3, out_partial, e1, e2, e3, ep);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 4'hC; s_flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check_bit("reset_s_ready", s_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_val("reset_trip_cnt", int'(trip_cnt), 0);
    check_ops("reset_ops", 4'h0, 4'h0, 4'h0, 1'b0);
    s_valid = 1'b0;
    rst = 1'b0;
    step();
    check_bit("post_reset_s_ready", s_ready, 1'b1);
    check_bit("post_reset_out_valid", out_valid, 1'b0);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(4'h3, 1'b0);
    send_word(4'h5, 1'b0);
    send_word(4'h9, 1'b0);
    check_bit("basic_valid_edge_k", out_valid, 1'b0);
    check_bit("basic_s_ready_full", s_ready, 1'b0);
    step();
    check_bit("basic_valid_edge_k1", out_valid, 1'b1);
    check_ops("basic_ops", 4'h3, 4'h5, 4'h9, 1'b0);
    check_val("basic_trip_cnt", int'(trip_cnt), 1);
    check_val("basic_adder", int'(adder_out), 1);
    check_bit("basic_s_ready_back", s_ready, 1'b1);
    step();
    check_bit("basic_valid_pulse_end", out_valid, 1'b0);
    check_ops("basic_ops_hold", 4'h3, 4'h5, 4'h9, 1'b0);
  endtask

  task automatic test_flush();
    send_word(4'h7, 1'b0);
    send_word(4'hF, 1'b1);
    step();
    check_bit("flush_valid", out_valid, 1'b1);
    check_ops("flush_ops", 4'h7, 4'hF, 4'h0, 1'b1);
    check_val("flush_adder", int'(adder_out), 6);
    check_val("flush_trip_cnt", int'(trip_cnt), 2);
    // s_flush without s_valid is ignored; next word lands in slot 0
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    send_word(4'h8, 1'b1);
    step();
    check_ops("flush_slot0_ops", 4'h8, 4'h0, 4'h0, 1'b1);
    check_val("flush_slot0_adder", int'(adder_out), 8);
    // flush on the 3rd word is a normal close
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h4, 1'b1);
    step();
    check_ops("flush_last_ops", 4'h1, 4'h2, 4'h4, 1'b0);
    check_val("flush_last_trip_cnt", int'(trip_cnt), 4);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_word(4'(i), 1'b0);
    step();
    check_bit("bp_s_ready_low", s_ready, 1'b0);
    check_bit("bp_out_valid", out_valid, 1'b1);
    check_ops("bp_first_held", 4'h1, 4'h2, 4'h3, 1'b0);
    s_valid = 1'b1; s_data = 4'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("bp_stall_s_ready", s_ready, 1'b0);
      check_ops("bp_stall_ops", 4'h1, 4'h2, 4'h3, 1'b0);
    end
    check_val("bp_trip_cnt_held", int'(trip_cnt), 5);
    s_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_ops("bp_release_ops", 4'h4, 4'h5, 4'h6, 1'b0);
    check_bit("bp_release_valid", out_valid, 1'b1);
    check_bit("bp_release_s_ready", s_ready, 1'b1);
    check_val("bp_release_trip_cnt", int'(trip_cnt), 6);
    check_val("bp_release_adder", int'(adder_out), 15);
    out_ready = 1'b1;
    step();
    check_bit("bp_drain_valid", out_valid, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_word(4'hA, 1'b0);
    send_word(4'hB, 1'b0);
    rst = 1'b1;
    #1;
    check_bit("rmid_s_ready_in_reset", s_ready, 1'b0);
    check_bit("rmid_out_valid_in_reset", out_valid, 1'b0);
    step();
    rst = 1'b0;
    step(); step();
    check_bit("rmid_no_residual", out_valid, 1'b0);
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h3, 1'b0);
    step();
    check_bit("rmid_valid", out_valid, 1'b1);
    check_ops("rmid_ops", 4'h1, 4'h2, 4'h3, 1'b0);
    check_val("rmid_trip_cnt", int'(trip_cnt), 1);
    step();
  endtask

  task automatic test_counter_wrap();
    // Counter is at 1 here; 255 more triplets bring it to 256 -> 0.
    for (int i = 0; i < 255; i++) send_word(4'(i), 1'b1);
    step(); step();
    check_val("wrap_trip_cnt_zero", int'(trip_cnt), 0);
    check_ops("wrap_last_ops", 4'hE, 4'h0, 4'h0, 1'b1);
    send_word(4'h9, 1'b0);
    send_word(4'h9, 1'b0);
    send_word(4'h9, 1'b0);
    step();
    check_val("wrap_trip_cnt_one", int'(trip_cnt), 1);
    check_ops("wrap_257_ops", 4'h9, 4'h9, 4'h9, 1'b0);
    check_val("wrap_257_adder", int'(adder_out), 11);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
